// File: rtl/mtm_alu_deserializer_p.sv
// mtm_alu_deserializer_p: serial-frame deserializer for the MTM ALU input path; CRC-4 check built only when MTM_DESER_CRC_EN is defined
module mtm_alu_deserializer_p #(
  parameter int OP_BYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sin,
  output logic [8*OP_BYTES-1:0] A,
  output logic [8*OP_BYTES-1:0] B,
  output logic [2:0]            OP,
  output logic                  out_valid,
  output logic                  err_data,
  output logic                  err_crc
);
  localparam int W  = 8*OP_BYTES;
  localparam int NF = 2*OP_BYTES;
  localparam int CW = $clog2(NF+1);
  typedef enum logic [2:0] {IDLE, TYPE, PAYLOAD, STOP, REPORT} state_t;
  state_t state, state_nxt;
  logic typ;
  logic [2:0] bit_cnt;
  logic [7:0] pay;
  logic [CW-1:0] frames;
  logic bad;
  logic [2*W-1:0] sr;
  logic crc_bad;
  logic frame_err;
  assign out_valid = state == REPORT;
  assign frame_err = bad | ~sin | (frames != CW'(NF));
  // state register
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_nxt;
  // frame sequencing: start, type, 8 payload bits, stop, one report cycle after a command
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = sin ? IDLE : TYPE;
      TYPE:    state_nxt = PAYLOAD;
      PAYLOAD: state_nxt = bit_cnt == 3'd7 ? STOP : PAYLOAD;
      STOP:    state_nxt = typ ? REPORT : IDLE;
      default: state_nxt = IDLE;
    endcase
  end
  // frame capture, packet bookkeeping and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      typ      <= 1'b0;
      bit_cnt  <= '0;
      pay      <= '0;
      frames   <= '0;
      bad      <= 1'b0;
      sr       <= '0;
      A        <= '0;
      B        <= '0;
      OP       <= '0;
      err_data <= 1'b0;
      err_crc  <= 1'b0;
    end else begin
      err_data <= 1'b0;
      err_crc  <= 1'b0;
      if (state == TYPE) typ <= sin;
      if (state == PAYLOAD) begin
        pay     <= {pay[6:0], sin};
        bit_cnt <= bit_cnt + 3'd1;
      end
      if (state == STOP && !typ) begin
        if (sin) begin
          sr <= {sr[2*W-9:0], pay};
          if (frames != CW'(NF+1)) frames <= frames + CW'(1);
        end else bad <= 1'b1;
      end
      if (state == STOP && typ) begin
        err_data <= frame_err;
        err_crc  <= ~frame_err & crc_bad;
        if (!frame_err && !crc_bad) begin
          B  <= sr[2*W-1:W];
          A  <= sr[W-1:0];
          OP <= pay[6:4];
        end
      end
      if (state == REPORT) begin
        frames <= '0;
        bad    <= 1'b0;
      end
    end
  end
`ifdef MTM_DESER_CRC_EN
  logic [3:0] crc;
  logic crc_in;
  logic fb;
  assign crc_in  = (typ && bit_cnt == 3'd0) ? 1'b1 : sin;
  assign fb      = crc[3] ^ crc_in;
  assign crc_bad = crc != pay[3:0];
  // serial x^4+x+1 over every data payload bit, then a constant 1 and the three opcode bits of the command
  always_ff @(posedge clk)
    if (rst || state == REPORT) crc <= '0;
    else if (state == PAYLOAD && (!typ || !bit_cnt[2])) crc <= {crc[2:1], crc[0] ^ fb, fb};
`else
  assign crc_bad = 1'b0;
`endif
endmodule

// File: doc/mtm_alu_deserializer_p.md
# mtm_alu_deserializer_p

Parametrised serial-frame deserializer for the MTM ALU input path. Receives the one-bit-per-clock `sin` stream, assembles two operands of configurable byte width plus a command frame, checks framing, frame count and CRC-4, and presents a complete operation to the ALU core with a one-cycle valid strobe. Successor to the fixed 32-bit deserializer; adds an operand-width parameter, explicit error reporting and a valid handshake.

## Interface
- `OP_BYTES`, default 4: bytes per operand (legal 1..8); operands are `8*OP_BYTES` bits.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `sin` in 1: serial input, idle high, one bit per `clk`.
- `A` out `8*OP_BYTES`: operand A.
- `B` out `8*OP_BYTES`: operand B.
- `OP` out 3: opcode from command frame.
- `out_valid` out 1: one-cycle strobe; `A`/`B`/`OP`/`err_*` meaningful this cycle.
- `err_data` out 1: framing or frame-count error, qualified by `out_valid`.
- `err_crc` out 1: CRC mismatch, qualified by `out_valid`.

## Operation
- Frame: 11 bits, MSB first: start `0`, type (`0` data, `1` command), 8 payload bits, stop `1`.
- Packet: `2*OP_BYTES` data frames (B bytes MSB-first, then A bytes MSB-first), then one command frame; command payload = {`0`, OP[2:0], CRC[3:0]}.
- FSM states: IDLE, TYPE, PAYLOAD (8-bit counter), STOP, REPORT.
  - IDLE: `sin`=0 -> TYPE; else stay.
  - TYPE: latch type bit -> PAYLOAD.
  - PAYLOAD: shift 8 bits -> STOP.
  - STOP: data frame with stop=1 -> store byte into shift register, increment frame counter, -> IDLE. Stop=0 on data frame -> set sticky `bad`, -> IDLE. Any command frame -> REPORT.
  - REPORT: drive outputs for one cycle -> IDLE.
- Frame counter width `$clog2(2*OP_BYTES+1)`; saturates at `2*OP_BYTES+1` (extra data frames never wrap).
- In REPORT: `err_data` = `bad` OR command stop bit=0 OR frame count ≠ `2*OP_BYTES`. `err_crc` = (not `err_data`) AND CRC mismatch.
- `A`, `B`, `OP` update only when both errors clear; otherwise hold previous values.
- REPORT always clears frame counter, `bad`, and CRC accumulator.
- CRC-4: polynomial x^4+x+1, init 0, over bit string {B, A, `1`, OP}, `16*OP_BYTES+4` bits, MSB first.
- Reset mid-packet aborts the packet silently; no `out_valid` for it.

## Timing
- Start bit sampled in cycle t, type in t+1, payload in t+2..t+9, stop in t+10.
- For a command frame: `out_valid` is high in cycle t+11 (REPORT), exactly one cycle. `A`/`B`/`OP` are updated in that same cycle and held afterwards.
- Earliest next start bit is sampled in t+12 (IDLE). A `0` on `sin` during REPORT is ignored.
- Back-to-back frames need no idle bits: a start bit may directly follow a data-frame stop bit.
- `rst` high in cycle n: from n+1 all state is IDLE and outputs are zero (`A`, `B` = 0, `OP` = 0, `out_valid` = 0, `err_data` = 0, `err_crc` = 0); counters, `bad` and CRC are cleared. `rst` dominates all other events.

## Configuration
- `MTM_DESER_CRC_EN` defined: CRC is computed and checked as above.
- Not defined: no CRC logic; `err_crc` is tied to 0 and command CRC bits are ignored. Framing and count checks are unchanged.

## Test plan
- Good packet, OP_BYTES=4: B=0x00000002, A=0x00000003, OP=3'b000, model CRC -> `out_valid` at t+11 of command start; A=0x00000003, B=0x00000002, OP=0; both errors 0.
- Same packet with CRC bit 0 flipped (CRC_EN defined) -> `out_valid`=1, `err_crc`=1, `err_data`=0, A/B/OP keep previous values. Without macro -> accepted as good.
- Only 7 data frames, then command -> `out_valid`=1, `err_data`=1, `err_crc`=0, outputs held. Also 9 data frames -> same; no counter wrap.
- Stop bit 0 on data frame 3, rest valid -> one `out_valid` at the command frame with `err_data`=1. Following good packet -> clean result.
- `rst` pulse after 5 data frames, then full good packet A=0xDEADBEEF, B=0x12345678, OP=3'b101 -> exactly one `out_valid`, values correct.
- OP_BYTES=1, B=0xA5, A=0x5A, OP=3'b001, back-to-back frames with no idle -> `out_valid` 11 cycles after command start bit, outputs match.
